// File: rtl/minc_loader_if.sv
// Program-memory write port between minc_loader and the minc core's
// 256x10 program ROM. The loader drives it; the memory receives it.
interface minc_loader_if;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [9:0] mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/minc_loader.sv
// minc_loader: receives a framed UART byte stream (sync byte, word count,
// then high/low byte pairs), writes 10-bit instruction words sequentially
// into program memory and holds the minc core in reset while loading.
module minc_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          RXD,
    minc_loader_if.master prog,
    output logic          cpu_nreset,
    output logic          busy,
    output logic          error
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_WAIT_SYNC,
        P_COUNT,
        P_HI,
        P_LO,
        P_ERR
    } p_state_t;

    // ------------------------------------------------------------------
    // RXD synchronizer and edge history
    // ------------------------------------------------------------------
    logic rxd_meta, rxd_sync, rxd_prev;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    // NOTE: these reset to 1 (idle line level) so leaving reset never looks
    // like a start-bit falling edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_t   rx_state, rx_state_d;
    logic [15:0] rx_cnt, rx_cnt_d;
    logic [2:0]  rx_bit, rx_bit_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic        rx_valid, rx_valid_d;
    logic        rx_ferr, rx_ferr_d;

    // UART state register; rx_valid/rx_ferr are registered one-cycle pulses.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            rx_valid <= rx_valid_d;
            rx_ferr  <= rx_ferr_d;
        end
    end

    // UART next-state: half-bit wait for the start bit, then full-bit steps.
    // NOTE: every output of this block is defaulted first so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rxd_prev && !rxd_sync)
                    rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rxd_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7)
                        rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rxd_sync;
                    rx_ferr_d  = !rxd_sync;
                end else begin
                    rx_cnt_d = rx_cnt + 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load protocol
    // ------------------------------------------------------------------
    p_state_t   p_state, p_state_d;
    logic [7:0] addr_cnt, addr_cnt_d;
    logic [8:0] remain, remain_d;
    logic [1:0] wd_hi, wd_hi_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [9:0] mem_wdata_q, mem_wdata_d;
    logic       cpu_nreset_d, busy_d, error_d;

    // Protocol state register and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            p_state     <= P_WAIT_SYNC;
            addr_cnt    <= '0;
            remain      <= '0;
            wd_hi       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_nreset  <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            p_state     <= p_state_d;
            addr_cnt    <= addr_cnt_d;
            remain      <= remain_d;
            wd_hi       <= wd_hi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_nreset  <= cpu_nreset_d;
            busy        <= busy_d;
            error       <= error_d;
        end
    end

    // Protocol next-state; status outputs follow the state being entered so
    // they change in the same cycle as the write strobe.
    always_comb begin
        p_state_d   = p_state;
        addr_cnt_d  = addr_cnt;
        remain_d    = remain;
        wd_hi_d     = wd_hi;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (rx_ferr) begin
            if (p_state != P_WAIT_SYNC)
                p_state_d = P_ERR;
        end else if (rx_valid) begin
            case (p_state)
                P_WAIT_SYNC, P_ERR: begin
                    if (rx_shift == SYNC_BYTE) begin
                        addr_cnt_d = '0;
                        p_state_d  = P_COUNT;
                    end
                end
                P_COUNT: begin
                    remain_d  = (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
                    p_state_d = P_HI;
                end
                P_HI: begin
                    wd_hi_d   = rx_shift[1:0];
                    p_state_d = (rx_shift[7:2] != 6'd0) ? P_ERR : P_LO;
                end
                P_LO: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_cnt;
                    mem_wdata_d = {wd_hi, rx_shift};
                    addr_cnt_d  = addr_cnt + 8'd1;
                    remain_d    = remain - 9'd1;
                    p_state_d   = (remain == 9'd1) ? P_WAIT_SYNC : P_HI;
                end
                default: p_state_d = P_WAIT_SYNC;
            endcase
        end

        cpu_nreset_d = (p_state_d == P_WAIT_SYNC);
        busy_d       = (p_state_d == P_COUNT) || (p_state_d == P_HI) || (p_state_d == P_LO);
        error_d      = (p_state_d == P_ERR);
    end

    assign prog.mem_we    = mem_we_q;
    assign prog.mem_addr  = mem_addr_q;
    assign prog.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_minc_loader.sv
// Directed testbench for minc_loader at CLKS_PER_BIT=4.
module tb_minc_loader;

    localparam int CPB = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic RXD;
    logic cpu_nreset, busy, error;

    minc_loader_if prog ();

    minc_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .RXD        (RXD),
        .prog       (prog),
        .cpu_nreset (cpu_nreset),
        .busy       (busy),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge away from register updates.
    logic [7:0] wr_addr [0:299];
    logic [9:0] wr_data [0:299];
    logic       wr_cpu  [0:299];
    logic       wr_busy [0:299];
    int         wr_cnt = 0;

    always @(negedge CLK) begin
        if (prog.mem_we === 1'b1 && wr_cnt < 300) begin
            wr_addr[wr_cnt] = prog.mem_addr;
            wr_data[wr_cnt] = prog.mem_wdata;
            wr_cpu[wr_cnt]  = cpu_nreset;
            wr_busy[wr_cnt] = busy;
            wr_cnt++;
        end
    end

    // Sends one 8N1 frame; called aligned to a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RXD = stop_bit;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b1;
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_outputs(input string tag, input logic we, input logic [7:0] a,
                                 input logic [9:0] d, input logic nr, input logic bz,
                                 input logic er);
        check({tag, "_we"},   32'(prog.mem_we),    32'(we));
        check({tag, "_addr"}, 32'(prog.mem_addr),  32'(a));
        check({tag, "_data"}, 32'(prog.mem_wdata), 32'(d));
        check({tag, "_nrst"}, 32'(cpu_nreset),     32'(nr));
        check({tag, "_busy"}, 32'(busy),           32'(bz));
        check({tag, "_err"},  32'(error),          32'(er));
    endtask

    initial begin
        int bad;
        logic [7:0] hb, lb;

        RESET = 1'b1;
        RXD   = 1'b1;
        repeat (3) @(negedge CLK);
        check_outputs("rst_hold", 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0);

        // Release: cpu_nreset still low until the next rising edge.
        RESET = 1'b0;
        #1;
        check("rel_before_edge_nrst", 32'(cpu_nreset), 32'd0);
        @(negedge CLK);
        check("rel_after_edge_nrst", 32'(cpu_nreset), 32'd1);
        check("rel_after_edge_busy", 32'(busy), 32'd0);

        // Asynchronous assertion mid-clock.
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1 check("async_rst_nrst", 32'(cpu_nreset), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("async_rel_nrst", 32'(cpu_nreset), 32'd1);

        // ---------------- Three-word load ----------------
        wr_cnt = 0;
        send_byte(8'hA5);
        idle(4);
        check("load_sync_busy", 32'(busy), 32'd1);
        check("load_sync_nrst", 32'(cpu_nreset), 32'd0);
        send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h07);
        send_byte(8'h01); send_byte(8'h00);
        idle(6);
        check("load_count", 32'(wr_cnt), 32'd3);
        check("load_a0", 32'(wr_addr[0]), 32'h00);
        check("load_d0", 32'(wr_data[0]), 32'h005);
        check("load_a1", 32'(wr_addr[1]), 32'h01);
        check("load_d1", 32'(wr_data[1]), 32'h007);
        check("load_a2", 32'(wr_addr[2]), 32'h02);
        check("load_d2", 32'(wr_data[2]), 32'h100);
        check("load_w0_nrst", 32'(wr_cpu[0]), 32'd0);
        check("load_w1_busy", 32'(wr_busy[1]), 32'd1);
        check("load_w2_nrst", 32'(wr_cpu[2]), 32'd1);
        check("load_w2_busy", 32'(wr_busy[2]), 32'd0);
        check_outputs("load_done", 1'b0, 8'h02, 10'h100, 1'b1, 1'b0, 1'b0);

        // ---------------- N=0 means 256 words ----------------
        wr_cnt = 0;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            hb = 8'(i & 3);
            lb = 8'(i) ^ 8'h5A;
            send_byte(hb);
            send_byte(lb);
        end
        idle(6);
        check("n0_count", 32'(wr_cnt), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (wr_addr[i] !== 8'(i)) bad++;
            if (wr_data[i] !== {2'(i & 3), 8'(i) ^ 8'h5A}) bad++;
            if (i < 255 && wr_cpu[i] !== 1'b0) bad++;
        end
        check("n0_words", 32'(bad), 32'd0);
        check("n0_last_addr", 32'(wr_addr[255]), 32'hFF);
        check("n0_last_nrst", 32'(wr_cpu[255]), 32'd1);
        check("n0_done_busy", 32'(busy), 32'd0);

        // ---------------- Bad high byte ----------------
        wr_cnt = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h04);
        idle(6);
        check("badhi_err", 32'(error), 32'd1);
        check("badhi_busy", 32'(busy), 32'd0);
        check("badhi_nrst", 32'(cpu_nreset), 32'd0);
        check("badhi_nowrite", 32'(wr_cnt), 32'd0);
        send_byte(8'h5A);
        idle(6);
        check("badhi_5a_err", 32'(error), 32'd1);
        check("badhi_5a_nrst", 32'(cpu_nreset), 32'd0);
        send_byte(8'hA5);
        idle(4);
        check("badhi_resync_err", 32'(error), 32'd0);
        check("badhi_resync_busy", 32'(busy), 32'd1);
        send_byte(8'h01); send_byte(8'h03); send_byte(8'hFF);
        idle(6);
        check("badhi_wr_count", 32'(wr_cnt), 32'd1);
        check("badhi_wr_addr", 32'(wr_addr[0]), 32'h00);
        check("badhi_wr_data", 32'(wr_data[0]), 32'h3FF);
        check("badhi_wr_nrst", 32'(cpu_nreset), 32'd1);

        // ---------------- Framing errors and glitches ----------------
        send_byte(8'hA5);
        send_byte(8'h33, 1'b0);
        idle(6);
        check("ferr_err", 32'(error), 32'd1);
        check("ferr_busy", 32'(busy), 32'd0);
        check("ferr_nrst", 32'(cpu_nreset), 32'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h2A);
        idle(6);
        check("ferr_recover_err", 32'(error), 32'd0);
        check("ferr_recover_data", 32'(prog.mem_wdata), 32'h02A);

        wr_cnt = 0;
        RXD = 1'b0;
        @(negedge CLK);
        RXD = 1'b1;
        idle(60);
        check("glitch_err", 32'(error), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        send_byte(8'h33, 1'b0);
        idle(6);
        check("ferr_idle_err", 32'(error), 32'd0);
        check("ferr_idle_nrst", 32'(cpu_nreset), 32'd1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        idle(6);
        check("glitch_after_count", 32'(wr_cnt), 32'd1);
        check("glitch_after_data", 32'(wr_data[0]), 32'h011);

        // ---------------- Reset mid-session ----------------
        wr_cnt = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
        idle(6);
        check("midrst_first_write", 32'(wr_cnt), 32'd1);
        // Begin the next high byte, then abort partway through.
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RXD = 1'b0;
            repeat (CPB) @(negedge CLK);
        end
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1 check_outputs("midrst_now", 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        idle(60);
        check("midrst_no_more_we", 32'(wr_cnt), 32'd1);
        check_outputs("midrst_after", 1'b0, 8'h00, 10'h000, 1'b1, 1'b0, 1'b0);
        send_byte(8'h11);
        idle(6);
        check("midrst_11_count", 32'(wr_cnt), 32'd1);
        check("midrst_11_busy", 32'(busy), 32'd0);
        check("midrst_11_nrst", 32'(cpu_nreset), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/minc_loader.md
# minc_loader

Serial program loader sitting directly upstream of the minc core's 256×10-bit program ROM. It receives a framed byte stream over a UART receive line, assembles 10-bit instruction words, and writes them sequentially into program memory through a simple write port. It holds the core in reset (`cpu_nreset` low) for the whole load, then releases it so execution starts from address 0 with the new program.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit; legal range 4..65535.
- `SYNC_BYTE`, default 8'hA5: byte that opens a load session.

- `CLK` in 1: system clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `RXD` in 1: UART receive line, 8N1, LSB first, idle high, asynchronous to `CLK`.
- `mem_we` out 1: one-cycle write strobe to program memory.
- `mem_addr` out 8: write address.
- `mem_wdata` out 10: instruction word; bits 9:8 are opcode, bits 7:0 immediate.
- `cpu_nreset` out 1: active-low reset for the minc core.
- `busy` out 1: high while a load session is in progress.
- `error` out 1: sticky error flag.

## Operation
- RXD passes through a 2-flop synchronizer before any use.
- UART RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge on the synchronized RXD enters START.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division), then resample. If high, treat as a glitch and return to IDLE with no byte and no error. If low, enter DATA.
  - DATA: sample 8 bits, each `CLKS_PER_BIT` cycles after the previous sample, LSB first.
  - STOP: sample once more after `CLKS_PER_BIT` cycles. A high sample yields `rx_valid` for one cycle. A low sample raises a framing error. In either case return to IDLE.
- Protocol FSM: WAIT_SYNC → COUNT → HI → LO → (HI | WAIT_SYNC); ERR.
  - WAIT_SYNC: bytes other than `SYNC_BYTE` are ignored. On `SYNC_BYTE`: `busy`=1, `cpu_nreset`=0, `error`=0, address counter=0, go to COUNT.
  - COUNT: the byte is word count N; 0 means 256. Go to HI.
  - HI: byte[1:0] becomes wdata[9:8]. If byte[7:2]≠0, go to ERR. Otherwise go to LO.
  - LO: byte becomes wdata[7:0]. Pulse `mem_we` with the current address, increment the address (8-bit wrap), decrement the remaining count. If remaining reaches 0, go to WAIT_SYNC with `busy`=0 and `cpu_nreset`=1. Otherwise go to HI.
  - A framing error in any state except WAIT_SYNC goes to ERR. A framing error in WAIT_SYNC is ignored.
  - ERR: `error`=1, `busy`=0, `cpu_nreset` held 0. Only `SYNC_BYTE` leaves ERR, restarting exactly as from WAIT_SYNC.
- Partially written memory is never cleared; a new session overwrites from address 0.
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_nreset`=0, `busy`=0, `error`=0. Both FSMs go to their idle states.
- `cpu_nreset` rises on the first `CLK` edge after `RESET` falls.
- `RESET` asserted mid-byte or mid-session aborts immediately. Any partially received byte is discarded, and `mem_we` must not pulse.

## Timing
- All outputs are registered.
- `rx_valid` occurs about 2 + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` cycles after the RXD falling edge. The jitter is ±1 cycle from synchronization.
- `mem_we`, `mem_addr` and `mem_wdata` are valid in the cycle after `rx_valid` of the LO byte. `mem_we` is high for exactly 1 cycle.
- `mem_addr` and `mem_wdata` hold their values until the next write.
- On the final word, `cpu_nreset` rises and `busy` falls in the same cycle as the `mem_we` pulse. The write therefore lands at the same edge the core leaves reset.
- The sync byte clears `error` and drops `cpu_nreset` in the cycle after its `rx_valid`.
- Back-to-back bytes are accepted: a new start bit may begin on the cycle after the stop-bit sample.

## Test plan
Use `CLKS_PER_BIT`=4 throughout.
- Reset: assert `RESET` mid-clock → all outputs 0 immediately. Release → `cpu_nreset`=1 on the next edge, `busy`=0.
- Load: send A5, 03, 00 05, 00 07, 01 00 → `mem_we` pulses at addr 0/1/2 with data 005/007/100. `busy`=1 throughout. `cpu_nreset`=0 from after A5 until it rises with the third write.
- N=0: send A5, 00, then 256 word pairs → 256 writes at addr 00..FF. `cpu_nreset` rises with the write to FF, and the address wraps to 00.
- Bad high byte: send A5, 02, 04 → `error`=1 and no write. Then send 5A → ignored. Then send A5, 01, 03 FF → `error`=0 and a write of 3FF at addr 0.
- Framing error: send A5, then a byte whose stop bit is 0 → ERR. Send a 1-cycle low glitch in WAIT_SYNC → no byte and no error.
- Reset mid-session: after A5, 02, 00 05, assert `RESET` during the next byte → no further `mem_we`, all outputs at reset values. Then send 11 → ignored.
